gmii_rx_frame: RTL and testbench

- Sits directly downstream of the GMII side of the RGMII/GMII converter, in the gmii_rx_clk domain.
- Consumes gmii_rx_dv/gmii_rxd and strips the preamble and SFD.
- Checks the Ethernet CRC-32 and frame length.
- Emits the frame bytes from destination MAC through the last payload byte, FCS excluded, as a valid/sop/eop byte stream with an end-of-frame error flag and length.

---
 rtl/eth_pkg.sv | 22 ++
 rtl/crc32_d8.sv | 21 ++
 rtl/gmii_rx_frame.sv | 179 +++++++++++++++++
 tb/tb_gmii_rx_frame.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet receive/transmit constants and the receive FSM state type.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    // Depth of the delay line that holds back the trailing FCS bytes.
    localparam int unsigned LINE_DEPTH = 5;
    localparam int unsigned FCS_BYTES  = 4;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        DROP
    } rx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte step of the reflected Ethernet CRC-32 (LSB first).
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    // Eight serial LFSR steps unrolled into one byte-wide update.
    always_comb begin
        c = crc_i ^ {24'h0, data_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/gmii_rx_frame.sv
// GMII receive framer: strips preamble/SFD, checks FCS and length, and emits
// DA..last payload byte as a valid/sop/eop stream with per-frame status.
module gmii_rx_frame
    import eth_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        gmii_rx_clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        rx_sop,
    output logic        rx_eop,
    output logic        rx_err,
    output logic [10:0] rx_len,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);

    rx_state_e       state_q, state_d;
    logic [2:0]      pcnt_q, pcnt_d;
    logic [31:0]     crc_q, crc_d, crc_next;
    logic [10:0]     bcnt_q, bcnt_d;
    logic [4:0][7:0] sr_q, sr_d;

    logic            valid_q, valid_d;
    logic [7:0]      data_q, data_d;
    logic            sop_q, sop_d;
    logic            eop_q, eop_d;
    logic            err_q, err_d;
    logic [10:0]     len_q, len_d;
    logic [15:0]     good_q, good_d;
    logic [15:0]     bad_q, bad_d;

    logic            line_full;
    logic            first_out;
    logic            frame_bad;

    crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (gmii_rxd),
        .crc_o  (crc_next)
    );

    // Once the line holds five bytes, its oldest byte is payload, never FCS.
    assign line_full = (bcnt_q >= 11'(LINE_DEPTH));
    assign first_out = (bcnt_q == 11'(LINE_DEPTH));
    assign frame_bad = (crc_q != CRC32_RESIDUE)
                     | (bcnt_q < 11'(MIN_LEN))
                     | (bcnt_q > 11'(MAX_LEN));

    // Next-state, delay-line and output-register logic.
    always_comb begin
        // NOTE: every _d gets a default first, so no path through the case leaves a latch.
        state_d = state_q;
        pcnt_d  = pcnt_q;
        crc_d   = crc_q;
        bcnt_d  = bcnt_q;
        sr_d    = sr_q;
        valid_d = 1'b0;
        data_d  = 8'h00;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        err_d   = 1'b0;
        len_d   = 11'd0;
        good_d  = good_q;
        bad_d   = bad_q;

        case (state_q)
            IDLE: begin
                if (gmii_rx_dv) begin
                    if (gmii_rxd == PREAMBLE_BYTE) begin
                        state_d = PRE;
                        pcnt_d  = 3'd1;
                    end else begin
                        state_d = DROP;
                    end
                end
            end

            PRE: begin
                if (!gmii_rx_dv) begin
                    state_d = IDLE;
                end else if (gmii_rxd == PREAMBLE_BYTE) begin
                    if (pcnt_q != 3'd7) pcnt_d = pcnt_q + 3'd1;
                end else if (gmii_rxd == SFD_BYTE) begin
                    state_d = DATA;
                    crc_d   = CRC32_INIT;
                    bcnt_d  = 11'd0;
                    sr_d    = '0;
                end else begin
                    state_d = DROP;
                end
            end

            DATA: begin
                if (gmii_rx_dv) begin
                    sr_d  = {sr_q[3:0], gmii_rxd};
                    crc_d = crc_next;
                    if (bcnt_q != 11'h7FF) bcnt_d = bcnt_q + 11'd1;
                    if (line_full) begin
                        valid_d = 1'b1;
                        data_d  = sr_q[4];
                        sop_d   = first_out;
                    end
                end else begin
                    // dv fell: the four newest bytes in the line are the FCS.
                    state_d = IDLE;
                    if (line_full) begin
                        valid_d = 1'b1;
                        data_d  = sr_q[4];
                        sop_d   = first_out;
                        eop_d   = 1'b1;
                        err_d   = frame_bad;
                        len_d   = bcnt_q - 11'(FCS_BYTES);
                        if (frame_bad) bad_d  = bad_q + 16'd1;
                        else           good_d = good_q + 16'd1;
                    end else begin
                        bad_d = bad_q + 16'd1;
                    end
                end
            end

            DROP: begin
                if (!gmii_rx_dv) state_d = IDLE;
            end

            default: state_d = DROP;
        endcase
    end

    // State, delay line and output registers; reset waits out any frame in flight.
    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DROP;
            pcnt_q  <= 3'd0;
            crc_q   <= CRC32_INIT;
            bcnt_q  <= 11'd0;
            // NOTE: the shift line is reset with the control state so no X can ever reach rx_data.
            sr_q    <= '0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            err_q   <= 1'b0;
            len_q   <= 11'd0;
            good_q  <= 16'd0;
            bad_q   <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples pre-edge values.
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            crc_q   <= crc_d;
            bcnt_q  <= bcnt_d;
            sr_q    <= sr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            err_q   <= err_d;
            len_q   <= len_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
        end
    end

    assign rx_valid = valid_q;
    assign rx_data  = data_q;
    assign rx_sop   = sop_q;
    assign rx_eop   = eop_q;
    assign rx_err   = err_q;
    assign rx_len   = len_q;
    assign good_cnt = good_q;
    assign bad_cnt  = bad_q;

endmodule

// File: tb/tb_gmii_rx_frame.sv
// Self-checking bench for gmii_rx_frame: frame-level table, hand-written corner
// sequences and randomized frames, all scored against a byte-queue model.
`timescale 1ns/1ps
module tb_gmii_rx_frame;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [7:0] data;
        bit         sop;
        bit         eop;
        bit         err;
        int         len;
    } beat_t;

    typedef struct {
        int npre;
        int dlen;
        bit rnd;
        bit bad_fcs;
        bit exp_emit;
        bit exp_err;
        int exp_len;
        int good_inc;
        int bad_inc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dv = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_sop;
    logic        rx_eop;
    logic        rx_err;
    logic [10:0] rx_len;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    int    n_cmp = 0;
    int    n_fail = 0;
    int    exp_good = 0;
    int    exp_bad = 0;
    beat_t exp_q[$];
    vec_t  vecs[11];

    gmii_rx_frame #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .gmii_rx_clk (clk),
        .rst_n       (rst_n),
        .gmii_rx_dv  (dv),
        .gmii_rxd    (rxd),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_sop      (rx_sop),
        .rx_eop      (rx_eop),
        .rx_err      (rx_err),
        .rx_len      (rx_len),
        .good_cnt    (good_cnt),
        .bad_cnt     (bad_cnt)
    );

    always #4 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Standard Ethernet FCS over the frame body (DA..payload), sent LSB byte first.
    function automatic logic [31:0] fcs_of(input bq_t d);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (d[i]) begin
            c ^= {24'h0, d[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic make_data(input int n, input bit rnd, output bq_t d);
        d = {};
        for (int i = 0; i < n; i++) d.push_back(rnd ? 8'($urandom) : 8'(i));
    endtask

    task automatic build_wire(input bq_t d, input int npre, input bit bad_fcs, output bq_t w);
        logic [31:0] f;
        logic [7:0]  b;
        w = {};
        repeat (npre) w.push_back(8'h55);
        w.push_back(8'hD5);
        foreach (d[i]) w.push_back(d[i]);
        f = fcs_of(d);
        for (int k = 0; k < 4; k++) begin
            b = f[8*k +: 8];
            if (bad_fcs && k == 3) b ^= 8'h01;
            w.push_back(b);
        end
    endtask

    task automatic drive_wire(input bq_t w, input int gap);
        foreach (w[i]) begin
            @(negedge clk);
            dv  = 1'b1;
            rxd = w[i];
        end
        repeat (gap) begin
            @(negedge clk);
            dv  = 1'b0;
            rxd = 8'h00;
        end
    endtask

    // Model: every body byte except the trailing 4 FCS bytes is emitted, in order.
    task automatic expect_frame(input bq_t d, input bit err, input int len);
        beat_t b;
        foreach (d[i]) begin
            b.data = d[i];
            b.sop  = (i == 0);
            b.eop  = (i == d.size() - 1);
            b.err  = err;
            b.len  = len;
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        @(negedge clk);
        #1;
        while (exp_q.size() != 0 && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        check({name, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_counters(input string name);
        check({name, "_good_cnt"}, good_cnt, 16'(exp_good));
        check({name, "_bad_cnt"}, bad_cnt, 16'(exp_bad));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_valid"}, rx_valid, 0);
        check({name, "_data"}, rx_data, 0);
        check({name, "_sop"}, rx_sop, 0);
        check({name, "_eop"}, rx_eop, 0);
        check({name, "_err"}, rx_err, 0);
        check({name, "_len"}, rx_len, 0);
        check({name, "_good_cnt"}, good_cnt, 0);
        check({name, "_bad_cnt"}, bad_cnt, 0);
    endtask

    task automatic good_frame(input string name, input int dlen);
        bq_t d, w;
        make_data(dlen, 1'b1, d);
        build_wire(d, 7, 1'b0, w);
        expect_frame(d, 1'b0, dlen);
        drive_wire(w, 2);
        wait_drain(name);
        exp_good++;
        check_counters(name);
    endtask

    // Scoreboard: every output beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_beat: got data 0x%02h sop %0d eop %0d, expected no beat (t=%0t)",
                         rx_data, rx_sop, rx_eop, $time);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_data", rx_data, e.data);
                check("beat_sop", rx_sop, e.sop);
                check("beat_eop", rx_eop, e.eop);
                if (e.eop) begin
                    check("eop_err", rx_err, e.err);
                    check("eop_len", rx_len, 32'(e.len));
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t d, w;

        //            npre dlen rnd bad emit err len  good bad
        vecs[0]  = '{7,  60,   0,  0,  1,   0,  60,   1,  0};  // 0x00..0x3B, good
        vecs[1]  = '{7,  60,   0,  1,  1,   1,  60,   0,  1};  // same, FCS corrupted
        vecs[2]  = '{7,  40,   1,  0,  1,   1,  40,   0,  1};  // 44 bytes: short
        vecs[3]  = '{7,  1519, 1,  0,  1,   1,  1519, 0,  1};  // 1523 bytes: long
        vecs[4]  = '{7,  1514, 1,  0,  1,   0,  1514, 1,  0};  // exactly MAX_LEN
        vecs[5]  = '{7,  1515, 1,  0,  1,   1,  1515, 0,  1};  // MAX_LEN+1
        vecs[6]  = '{7,  59,   1,  0,  1,   1,  59,   0,  1};  // MIN_LEN-1
        vecs[7]  = '{12, 60,   1,  0,  1,   0,  60,   1,  0};  // long preamble
        vecs[8]  = '{1,  60,   1,  0,  1,   0,  60,   1,  0};  // single preamble byte
        vecs[9]  = '{7,  1,    1,  0,  1,   1,  1,    0,  1};  // 5 bytes: sop=eop
        vecs[10] = '{7,  0,    1,  0,  0,   0,  0,    0,  1};  // runt: SFD + 4 bytes

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("post_reset");

        // Table-driven frames.
        for (int i = 0; i < 11; i++) begin
            make_data(vecs[i].dlen, vecs[i].rnd, d);
            build_wire(d, vecs[i].npre, vecs[i].bad_fcs, w);
            if (vecs[i].exp_emit) expect_frame(d, vecs[i].exp_err, vecs[i].exp_len);
            drive_wire(w, 2);
            wait_drain($sformatf("vec%0d", i));
            exp_good += vecs[i].good_inc;
            exp_bad  += vecs[i].bad_inc;
            check_counters($sformatf("vec%0d", i));
        end

        // Preamble aborted by dv falling: nothing emitted, no counter change.
        w = {8'h55, 8'h55, 8'h55};
        drive_wire(w, 2);
        wait_drain("pre_abort");
        check_counters("pre_abort");

        // Frame whose first byte is not preamble: dropped whole.
        make_data(30, 1'b1, d);
        build_wire(d, 7, 1'b0, w);
        w.push_front(8'h12);
        drive_wire(w, 2);
        wait_drain("garbage_start");
        check_counters("garbage_start");
        good_frame("after_drop", 60);

        // Back-to-back 64-byte frames with exactly one idle cycle between them.
        begin
            bq_t d2, w2;
            make_data(60, 1'b1, d);
            make_data(60, 1'b1, d2);
            build_wire(d, 7, 1'b0, w);
            build_wire(d2, 7, 1'b0, w2);
            expect_frame(d, 1'b0, 60);
            expect_frame(d2, 1'b0, 60);
            drive_wire(w, 1);
            drive_wire(w2, 2);
            wait_drain("b2b");
            exp_good += 2;
            check_counters("b2b");
        end

        // Randomized frames against the spec-level model.
        for (int r = 0; r < 40; r++) begin
            bit garbage, bad;
            int dlen, n;
            garbage = ($urandom_range(0, 9) == 0);
            bad     = ($urandom_range(0, 3) == 0);
            dlen    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1400, 1530))
                                                 : int'($urandom_range(0, 100));
            make_data(dlen, 1'b1, d);
            build_wire(d, int'($urandom_range(1, 10)), bad, w);
            n = dlen + 4;
            if (garbage) begin
                w.push_front(8'h12);
            end else if (n < 5) begin
                exp_bad++;
            end else begin
                bit err;
                err = bad || (n < 64) || (n > 1518);
                expect_frame(d, err, dlen);
                if (err) exp_bad++;
                else     exp_good++;
            end
            drive_wire(w, int'($urandom_range(1, 4)));
            wait_drain($sformatf("rnd%0d", r));
            check_counters($sformatf("rnd%0d", r));
        end

        // Reset pulsed mid-payload: outputs clear at once, remainder of frame ignored.
        make_data(40, 1'b1, d);
        build_wire(d, 7, 1'b0, w);
        for (int i = 0; i < 15; i++) begin
            beat_t b;
            b.data = d[i];
            b.sop  = (i == 0);
            b.eop  = 1'b0;
            b.err  = 1'b0;
            b.len  = 0;
            exp_q.push_back(b);
        end
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            dv  = 1'b1;
            rxd = w[i];
        end
        @(negedge clk);
        rxd = w[28];
        #2;
        rst_n = 1'b0;
        #1;
        exp_good = 0;
        exp_bad  = 0;
        check_all_zero("mid_reset");
        check("mid_reset_beats_seen", exp_q.size(), 0);
        exp_q.delete();
        for (int i = 29; i < w.size(); i++) begin
            @(negedge clk);
            dv  = 1'b1;
            rxd = w[i];
            if (i == 31) begin
                #2;
                rst_n = 1'b1;
            end
        end
        repeat (2) begin
            @(negedge clk);
            dv  = 1'b0;
            rxd = 8'h00;
        end
        wait_drain("mid_reset_tail");
        check_counters("mid_reset_tail");
        good_frame("after_reset", 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
